// File: rtl/regfile_pkg.sv
// Shared widths and write-back source encoding for the register-file write path.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is granted.
import regfile_pkg::*;

module rr_arb2 (
  input  logic    req_a,
  input  logic    req_b,
  input  wb_src_e last,
  output logic    gnt_a,
  output logic    gnt_b
);
  assign gnt_a = req_a & (~req_b | (last == WB_SRC_B));
  assign gnt_b = req_b & (~req_a | (last == WB_SRC_A));
endmodule

// File: rtl/regfile_wb_arb.sv
// Arbitrates execute and load write-backs onto the single register-file write port.
import regfile_pkg::*;

module regfile_wb_arb (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_hold,
  input  logic                  i_a_valid,
  input  logic [REG_ADDR_W-1:0] i_a_addr,
  input  logic [XLEN-1:0]       i_a_data,
  output logic                  o_a_ready,
  input  logic                  i_b_valid,
  input  logic [REG_ADDR_W-1:0] i_b_addr,
  input  logic [XLEN-1:0]       i_b_data,
  output logic                  o_b_ready,
  output logic                  o_wr_en,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic                  o_conflict
);
  wb_src_e               last_q;
  logic                  req_a;
  logic                  req_b;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  xfer;
  logic                  wr_ok;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]       win_data;

  assign req_a = i_a_valid & ~i_hold;
  assign req_b = i_b_valid & ~i_hold;

  rr_arb2 u_arb (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last_q),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign o_a_ready = gnt_a;
  assign o_b_ready = gnt_b;

  assign xfer     = gnt_a | gnt_b;
  assign win_addr = gnt_a ? i_a_addr : i_b_addr;
  assign win_data = gnt_a ? i_a_data : i_b_data;
  // x0 writes are consumed upstream but never reach the register file
  assign wr_ok    = xfer & (win_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= WB_SRC_B;
    end else if (gnt_a) begin
      last_q <= WB_SRC_A;
    end else if (gnt_b) begin
      last_q <= WB_SRC_B;
    end
  end

  // address/data only move when a real write is issued, otherwise they hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_en    <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_conflict <= 1'b0;
    end else begin
      o_wr_en    <= wr_ok;
      o_conflict <= i_a_valid & i_b_valid & ~i_hold;
      if (wr_ok) begin
        o_rd_addr <= win_addr;
        o_rd_data <= win_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench with a cycle-level reference model of the write-back arbiter.
module tb_regfile_wb_arb;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_hold = 1'b0;
  logic        i_a_valid = 1'b0;
  logic [4:0]  i_a_addr = '0;
  logic [31:0] i_a_data = '0;
  logic        o_a_ready;
  logic        i_b_valid = 1'b0;
  logic [4:0]  i_b_addr = '0;
  logic [31:0] i_b_data = '0;
  logic        o_b_ready;
  logic        o_wr_en;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_conflict;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_wr_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_conf = 1'b0;
  logic        m_last_b = 1'b1;
  logic        a_pend = 1'b0, b_pend = 1'b0;
  logic [4:0]  a_sav_addr, b_sav_addr;
  logic [31:0] a_sav_data, b_sav_data;

  regfile_wb_arb dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_hold     (i_hold),
    .i_a_valid  (i_a_valid),
    .i_a_addr   (i_a_addr),
    .i_a_data   (i_a_data),
    .o_a_ready  (o_a_ready),
    .i_b_valid  (i_b_valid),
    .i_b_addr   (i_b_addr),
    .i_b_data   (i_b_data),
    .o_b_ready  (o_b_ready),
    .o_wr_en    (o_wr_en),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_conflict (o_conflict)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {grant_a, grant_b} from the arbitration rules
  function automatic logic [1:0] exp_grant();
    if (i_hold) return 2'b00;
    if (i_a_valid && i_b_valid) return m_last_b ? 2'b10 : 2'b01;
    if (i_a_valid) return 2'b10;
    if (i_b_valid) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wr_en  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_conf   = 1'b0;
    m_last_b = 1'b1;
    a_pend   = 1'b0;
    b_pend   = 1'b0;
  endtask

  always @(negedge i_rst_n) model_reset();

  always @(posedge i_clk) begin
    logic [1:0] g;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      if (a_pend && i_a_valid) begin
        chk("a_stable_addr", {27'd0, i_a_addr}, {27'd0, a_sav_addr});
        chk("a_stable_data", i_a_data, a_sav_data);
      end
      if (b_pend && i_b_valid) begin
        chk("b_stable_addr", {27'd0, i_b_addr}, {27'd0, b_sav_addr});
        chk("b_stable_data", i_b_data, b_sav_data);
      end
      g = exp_grant();
      a_pend = i_a_valid && !g[1];
      b_pend = i_b_valid && !g[0];
      a_sav_addr = i_a_addr; a_sav_data = i_a_data;
      b_sav_addr = i_b_addr; b_sav_data = i_b_data;
      m_conf = i_a_valid && i_b_valid && !i_hold;
      m_wr_en = 1'b0;
      if (g[1]) begin
        m_last_b = 1'b0;
        if (i_a_addr != 0) begin m_wr_en = 1'b1; m_addr = i_a_addr; m_data = i_a_data; end
      end else if (g[0]) begin
        m_last_b = 1'b1;
        if (i_b_addr != 0) begin m_wr_en = 1'b1; m_addr = i_b_addr; m_data = i_b_data; end
      end
    end
  end

  always @(negedge i_clk) begin
    logic [1:0] g;
    g = exp_grant();
    chk("m_a_ready", {31'd0, o_a_ready}, {31'd0, g[1]});
    chk("m_b_ready", {31'd0, o_b_ready}, {31'd0, g[0]});
    chk("m_wr_en", {31'd0, o_wr_en}, {31'd0, m_wr_en});
    chk("m_rd_addr", {27'd0, o_rd_addr}, {27'd0, m_addr});
    chk("m_rd_data", o_rd_data, m_data);
    chk("m_conflict", {31'd0, o_conflict}, {31'd0, m_conf});
  end

  // drive one cycle just after the edge, return mid-cycle for literal checks
  task automatic step(input logic h, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    @(posedge i_clk);
    #2;
    i_hold = h;
    i_a_valid = av; i_a_addr = aa; i_a_data = ad;
    i_b_valid = bv; i_b_addr = ba; i_b_data = bd;
    @(negedge i_clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_out(input string name, input logic we, input logic [4:0] ad, input logic [31:0] dt);
    chk({name, "_wr_en"}, {31'd0, o_wr_en}, {31'd0, we});
    chk({name, "_addr"}, {27'd0, o_rd_addr}, {27'd0, ad});
    chk({name, "_data"}, o_rd_data, dt);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    chk_out("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_conflict", {31'd0, o_conflict}, 32'd0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  initial begin
    @(negedge i_clk);
    chk_out("por", 1'b0, 5'd0, 32'd0);
    chk("por_conflict", {31'd0, o_conflict}, 32'd0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;

    // single request from A
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("single_a_ready", {31'd0, o_a_ready}, 32'd1);
    idle();
    chk_out("single", 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    chk_out("single_hold_val", 1'b0, 5'd5, 32'hDEADBEEF);

    // contention after reset alternates A,B,A,B
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      chk("rr_a_ready", {31'd0, o_a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_ready", {31'd0, o_b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk_out("rr", 1'b1, (k % 2 == 1) ? 5'd1 : 5'd2, (k % 2 == 1) ? 32'h11 : 32'h22);
        chk("rr_conflict", {31'd0, o_conflict}, 32'd1);
      end
    end
    idle();
    chk_out("rr_last", 1'b1, 5'd2, 32'h22);
    chk("rr_last_conflict", {31'd0, o_conflict}, 32'd1);

    // x0 write from B is consumed but dropped
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
    chk("x0_b_ready", {31'd0, o_b_ready}, 32'd1);
    chk("x0_conflict_clr", {31'd0, o_conflict}, 32'd0);
    idle();
    chk_out("x0", 1'b0, 5'd2, 32'h22);

    // hold blocks grants and does not disturb round-robin state
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      chk("hold_a_ready", {31'd0, o_a_ready}, 32'd0);
      chk("hold_b_ready", {31'd0, o_b_ready}, 32'd0);
      chk("hold_wr_en", {31'd0, o_wr_en}, 32'd0);
    end
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    chk("release_a_ready", {31'd0, o_a_ready}, 32'd1);
    chk("release_b_ready", {31'd0, o_b_ready}, 32'd0);

    // reset cancels an in-flight write
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    chk("pre_rst_a_ready", {31'd0, o_a_ready}, 32'd1);
    chk_out("pre_rst", 1'b1, 5'd3, 32'h33);
    #2 i_rst_n = 1'b0;
    #1 chk_out("rst_async", 1'b0, 5'd0, 32'd0);
    idle();
    chk_out("rst_mid1", 1'b0, 5'd0, 32'd0);
    idle();
    chk_out("rst_mid2", 1'b0, 5'd0, 32'd0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    chk("post_rst_a_ready", {31'd0, o_a_ready}, 32'd1);
    chk("post_rst_wr_en", {31'd0, o_wr_en}, 32'd0);

    // streaming from A with no bubble
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 5'(k), 32'(k * 256), 1'b0, 5'd0, 32'd0);
      chk("stream_a_ready", {31'd0, o_a_ready}, 32'd1);
      if (k == 1) chk_out("stream_first", 1'b1, 5'd9, 32'h99);
      else chk_out("stream", 1'b1, 5'(k - 1), 32'((k - 1) * 256));
    end
    idle();
    chk_out("stream_last", 1'b1, 5'd8, 32'h800);
    idle();
    chk("stream_end_wr_en", {31'd0, o_wr_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-002 Port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-003 Port i_hold  input  1  global write-back stall; blocks all grants while high.
REQ-004 Port i_a_valid  input  1  requester A (execute write-back) has a write pending.
REQ-005 Port i_a_addr  input  5  requester A destination register index.
REQ-006 Port i_a_data  input  32  requester A write data.
REQ-007 Port o_a_ready  output  1  requester A granted this cycle.
REQ-008 Port i_b_valid  input  1  requester B (load write-back) has a write pending.
REQ-009 Port i_b_addr  input  5  requester B destination register index.
REQ-010 Port i_b_data  input  32  requester B write data.
REQ-011 Port o_b_ready  output  1  requester B granted this cycle.
REQ-012 Port o_wr_en  output  1  register-file write enable.
REQ-013 Port o_rd_addr  output  5  register-file destination index.
REQ-014 Port o_rd_data  output  32  register-file write data.
REQ-015 Port o_conflict  output  1  registered flag: previous cycle had both requesters valid and not held.

Function
REQ-016 A transfer occurs on a port in any cycle where its valid and ready are both high; the transfer is consumed in that cycle.
REQ-017 Ready is combinational from valid, i_hold and the round-robin state; valid never depends on ready.
REQ-018 i_hold high: o_a_ready = o_b_ready = 0.
REQ-019 i_hold low, exactly one valid: that requester is granted.
REQ-020 i_hold low, both valid: grant the requester not granted last (round-robin); at most one ready high per cycle.
REQ-021 The last-granted register updates only on a transfer; no transfer leaves it unchanged.
REQ-022 Output is registered, latency 1: a transfer in cycle N drives o_wr_en=1 with that addr and data in cycle N+1.
REQ-023 A cycle with no transfer drives o_wr_en=0 in the next cycle; o_rd_addr and o_rd_data hold their previous values.
REQ-024 A transfer with addr 0 is consumed, but o_wr_en=0 in the next cycle (x0 writes dropped).
REQ-025 A requester holding valid while not granted keeps addr and data stable; the arbiter does not check this, but it is a bench assertion.
REQ-026 Back-to-back transfers are allowed every cycle with no bubble; sustained throughput is one write per cycle.
REQ-027 o_conflict(N+1) = i_a_valid & i_b_valid & ~i_hold in cycle N.

Reset
REQ-028 Asserting i_rst_n low immediately forces o_wr_en=0, o_rd_addr=0, o_rd_data=0 and o_conflict=0, and sets last-granted to B so A wins the first tie.
REQ-029 Reset asserted during a pending output write cancels that write; it never reaches the register file.
REQ-030 Ready outputs during reset follow REQ-017 to REQ-020 using last-granted = B; the upstream blocks are held in reset at the same time.

Structure
REQ-031 A shared package regfile_pkg holds XLEN=32, REG_ADDR_W=5, and the enum wb_src_e {WB_SRC_A, WB_SRC_B}; all widths derive from it.
REQ-032 The two-way round-robin grant logic (request pair and last-granted in, one-hot grant out) is one sub-module, rr_arb2; output registering stays in regfile_wb_arb.
REQ-033 o_wr_en, o_rd_addr and o_rd_data connect directly to the register-file write port with no extra logic.

Verification
REQ-034 Single request: A valid with addr=5, data=0xDEADBEEF, hold=0 -> o_a_ready=1 in cycle N; in N+1 o_wr_en=1, o_rd_addr=5, o_rd_data=0xDEADBEEF.
REQ-035 Contention after reset: A and B both valid for 4 cycles (A addr=1, B addr=2) -> grants A,B,A,B; o_wr_en high in cycles N+1..N+4 with addr 1,2,1,2; o_conflict=1 in N+1..N+4.
REQ-036 x0 drop: B valid with addr=0, data=0x12345678 -> o_b_ready=1; next cycle o_wr_en=0.
REQ-037 Hold: both valid with i_hold=1 for 3 cycles, then i_hold=0 -> no ready and o_wr_en=0 during the hold; first grant after release goes to A (last-granted unchanged at B).
REQ-038 Reset mid-operation: transfer from A (addr=7) in cycle N, i_rst_n low before the edge at N+1 -> o_wr_en=0 and o_rd_addr=0 throughout reset; first tie after release is granted to A.
REQ-039 Streaming: A valid for 8 consecutive cycles with addr 1..8 and B idle -> 8 consecutive o_wr_en pulses with addr 1..8 and no bubble.
